// File: rtl/point_sequencer.sv
// Sweeps stored model points through the projection stage and hands the
// clipped screen coordinates to the renderer one valid/ready transfer at a time.
module point_sequencer #(
    parameter int N_TRACKING_POINTS = 4,
    parameter int N_VIRTUAL_POINTS  = 8,
    parameter int PROJ_LATENCY      = 1,
    parameter int H_ACTIVE          = 1024,
    parameter int V_ACTIVE          = 768
) (
    input  logic                                        clk_in,
    input  logic                                        rst_n_in,
    input  logic                                        frame_start_in,
    input  logic                                        basis_valid_in,
    input  logic                                        wr_en_in,
    input  logic [$clog2(N_VIRTUAL_POINTS)-1:0]         wr_addr_in,
    input  logic signed [(N_TRACKING_POINTS-1)*16-1:0]  wr_scalars_in,
    input  logic [3:0]                                  wr_color_in,
    output logic signed [(N_TRACKING_POINTS-1)*16-1:0]  point_scalars_out,
    output logic [3:0]                                  point_color_out,
    input  logic signed [31:0]                          x_proj_in,
    input  logic signed [31:0]                          y_proj_in,
    input  logic [3:0]                                  color_proj_in,
    output logic                                        pt_valid_out,
    input  logic                                        pt_ready_in,
    output logic [10:0]                                 pt_x_out,
    output logic [9:0]                                  pt_y_out,
    output logic [3:0]                                  pt_color_out,
    output logic                                        pt_visible_out,
    output logic                                        pt_last_out,
    output logic                                        busy_out,
    output logic                                        done_out,
    output logic                                        overrun_out
);

    localparam int unsigned SW = (N_TRACKING_POINTS - 1) * 16;
    localparam int unsigned IW = $clog2(N_VIRTUAL_POINTS);
    localparam int unsigned LW = (PROJ_LATENCY > 0) ? $clog2(PROJ_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PRESENT
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_next;
    logic [LW-1:0]    lat_cnt;
    logic [SW-1:0]    scal_mem  [N_VIRTUAL_POINTS];
    logic [3:0]       color_mem [N_VIRTUAL_POINTS];

    logic [10:0]      x_clip;
    logic [9:0]       y_clip;
    logic             x_in;
    logic             y_in;

    // Signed clamp of the projected coordinates onto the active display.
    always_comb begin
        x_clip = '0;
        x_in   = 1'b0;
        if (x_proj_in < 32'sd0) begin
            x_clip = '0;
        end else if (x_proj_in >= H_ACTIVE) begin
            x_clip = 11'(H_ACTIVE - 1);
        end else begin
            x_clip = x_proj_in[10:0];
            x_in   = 1'b1;
        end
    end

    always_comb begin
        y_clip = '0;
        y_in   = 1'b0;
        if (y_proj_in < 32'sd0) begin
            y_clip = '0;
        end else if (y_proj_in >= V_ACTIVE) begin
            y_clip = 10'(V_ACTIVE - 1);
        end else begin
            y_clip = y_proj_in[9:0];
            y_in   = 1'b1;
        end
    end

    always_comb begin
        idx_next = idx + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            idx               <= '0;
            lat_cnt           <= '0;
            point_scalars_out <= '0;
            point_color_out   <= '0;
            pt_valid_out      <= 1'b0;
            pt_x_out          <= '0;
            pt_y_out          <= '0;
            pt_color_out      <= '0;
            pt_visible_out    <= 1'b0;
            pt_last_out       <= 1'b0;
            busy_out          <= 1'b0;
            done_out          <= 1'b0;
            overrun_out       <= 1'b0;
            for (int unsigned i = 0; i < N_VIRTUAL_POINTS; i++) begin
                scal_mem[i]  <= '0;
                color_mem[i] <= '0;
            end
        end else begin
            done_out    <= 1'b0;
            overrun_out <= 1'b0;

            // The memory is frozen for the whole sweep so every point of a frame is coherent.
            if (wr_en_in && !busy_out) begin
                scal_mem[wr_addr_in]  <= wr_scalars_in;
                color_mem[wr_addr_in] <= wr_color_in;
            end

            if (frame_start_in && busy_out) begin
                overrun_out <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_start_in && basis_valid_in) begin
                        idx               <= '0;
                        point_scalars_out <= scal_mem[0];
                        point_color_out   <= color_mem[0];
                        busy_out          <= 1'b1;
                        lat_cnt           <= '0;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LW'(PROJ_LATENCY)) begin
                        pt_x_out       <= x_clip;
                        pt_y_out       <= y_clip;
                        pt_color_out   <= color_proj_in;
                        pt_visible_out <= x_in && y_in;
                        pt_last_out    <= (idx == IW'(N_VIRTUAL_POINTS - 1));
                        pt_valid_out   <= 1'b1;
                        state          <= PRESENT;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (pt_ready_in) begin
                        pt_valid_out <= 1'b0;
                        if (pt_last_out) begin
                            busy_out <= 1'b0;
                            done_out <= 1'b1;
                            idx      <= '0;
                            state    <= IDLE;
                        end else begin
                            idx               <= idx_next;
                            point_scalars_out <= scal_mem[idx_next];
                            point_color_out   <= color_mem[idx_next];
                            lat_cnt           <= '0;
                            state             <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_point_sequencer.sv
// Bench for point_sequencer: a registered projection-stage model feeds the DUT,
// and a scoreboard checks each renderer handshake against the point table.
module tb_point_sequencer;

    localparam int NT = 4;
    localparam int NV = 8;
    localparam int PL = 1;
    localparam int HA = 1024;
    localparam int VA = 768;
    localparam int SW = (NT - 1) * 16;

    // Projection stage: x_vec={0,0,256}, y_vec={256,0,0}, origin (100,50).
    localparam int XV0 = 256, XV1 = 0, XV2 = 0, XO = 100;
    localparam int YV0 = 0,   YV1 = 0, YV2 = 256, YO = 50;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  frame_start = 1'b0;
    logic                  basis_valid = 1'b0;
    logic                  wr_en = 1'b0;
    logic [2:0]            wr_addr = '0;
    logic signed [SW-1:0]  wr_scalars = '0;
    logic [3:0]            wr_color = '0;
    logic signed [SW-1:0]  point_scalars;
    logic [3:0]            point_color;
    logic signed [31:0]    x_proj = '0;
    logic signed [31:0]    y_proj = '0;
    logic [3:0]            color_proj = '0;
    logic                  pt_valid;
    logic                  pt_ready = 1'b0;
    logic [10:0]           pt_x;
    logic [9:0]            pt_y;
    logic [3:0]            pt_color;
    logic                  pt_visible;
    logic                  pt_last;
    logic                  busy;
    logic                  done;
    logic                  overrun;

    point_sequencer #(
        .N_TRACKING_POINTS (NT),
        .N_VIRTUAL_POINTS  (NV),
        .PROJ_LATENCY      (PL),
        .H_ACTIVE          (HA),
        .V_ACTIVE          (VA)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .frame_start_in    (frame_start),
        .basis_valid_in    (basis_valid),
        .wr_en_in          (wr_en),
        .wr_addr_in        (wr_addr),
        .wr_scalars_in     (wr_scalars),
        .wr_color_in       (wr_color),
        .point_scalars_out (point_scalars),
        .point_color_out   (point_color),
        .x_proj_in         (x_proj),
        .y_proj_in         (y_proj),
        .color_proj_in     (color_proj),
        .pt_valid_out      (pt_valid),
        .pt_ready_in       (pt_ready),
        .pt_x_out          (pt_x),
        .pt_y_out          (pt_y),
        .pt_color_out      (pt_color),
        .pt_visible_out    (pt_visible),
        .pt_last_out       (pt_last),
        .busy_out          (busy),
        .done_out          (done),
        .overrun_out       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       s2, s1, s0;
        logic [3:0] c;
        int       ex, ey;
        logic     ev;
    } vec_t;

    typedef struct {
        int         idx;
        logic [10:0] x;
        logic [9:0]  y;
        logic [3:0]  c;
        logic        vis;
        logic        last;
    } exp_t;

    vec_t  tbl [NV];
    exp_t  sbq [$];
    exp_t  mon_e;
    int    hs_edge [$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    done_count = 0;

    function automatic int proj(logic [SW-1:0] sc, int v0, int v1, int v2, int org);
        logic signed [15:0] s0, s1, s2;
        int sum;
        s0  = sc[15:0];
        s1  = sc[31:16];
        s2  = sc[47:32];
        sum = int'(s0) * v0 + int'(s1) * v1 + int'(s2) * v2;
        return org + (sum >>> 8);
    endfunction

    always @(posedge clk) begin
        x_proj     <= proj(point_scalars, XV0, XV1, XV2, XO);
        y_proj     <= proj(point_scalars, YV0, YV1, YV2, YO);
        color_proj <= point_color;
        cyc        <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && pt_valid && pt_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_point", 64'(1), 64'(0));
            end else begin
                mon_e = sbq.pop_front();
                chk($sformatf("pt%0d_x", mon_e.idx),     64'(pt_x),       64'(mon_e.x));
                chk($sformatf("pt%0d_y", mon_e.idx),     64'(pt_y),       64'(mon_e.y));
                chk($sformatf("pt%0d_color", mon_e.idx), 64'(pt_color),   64'(mon_e.c));
                chk($sformatf("pt%0d_vis", mon_e.idx),   64'(pt_visible), 64'(mon_e.vis));
                chk($sformatf("pt%0d_last", mon_e.idx),  64'(pt_last),    64'(mon_e.last));
            end
            hs_edge.push_back(cyc + 1);
            hs_count++;
        end
        if (done) done_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pt(input int addr, input vec_t v);
        wr_en      = 1'b1;
        wr_addr    = 3'(addr);
        wr_scalars = {16'(v.s2), 16'(v.s1), 16'(v.s0)};
        wr_color   = v.c;
        tick();
        wr_en      = 1'b0;
    endtask

    task automatic push_frame(input bit cleared);
        exp_t e;
        for (int i = 0; i < NV; i++) begin
            e.idx  = i;
            e.x    = cleared ? 11'(100) : 11'(tbl[i].ex);
            e.y    = cleared ? 10'(50)  : 10'(tbl[i].ey);
            e.c    = cleared ? 4'd0     : tbl[i].c;
            e.vis  = cleared ? 1'b1     : tbl[i].ev;
            e.last = (i == NV - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!pt_valid && n < 30) begin
            tick();
            n++;
        end
        chk(name, 64'(pt_valid), 64'(1));
    endtask

    task automatic wait_hs(input string name, input int target);
        int n = 0;
        while (hs_count < target && n < 200) begin
            tick();
            n++;
        end
        chk(name, 64'(hs_count), 64'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, 64'({pt_valid, busy, done, overrun, pt_visible, pt_last}), 64'(0));
        chk({tag, "_pt_xy"}, 64'({pt_x, pt_y, pt_color}), 64'(0));
        chk({tag, "_point"}, 64'({point_scalars, point_color}), 64'(0));
    endtask

    initial begin
        int n;
        int done_edge;
        int dc;
        logic [26:0] snap;

        //             s2    s1  s0    c      ex    ey   ev
        tbl[0] = '{    0,    3,  256,  4'd5,  356,  50, 1'b1};
        tbl[1] = '{    0,    3, -120,  4'd1,    0,  50, 1'b0};
        tbl[2] = '{    0,    3,  924,  4'd2, 1023,  50, 1'b0};
        tbl[3] = '{  750,    3,    0,  4'd3,  100, 767, 1'b0};
        tbl[4] = '{  717,    3,  923,  4'd4, 1023, 767, 1'b1};
        tbl[5] = '{  -50,    3, -100,  4'd6,    0,   0, 1'b1};
        tbl[6] = '{  -60,    3, 1000,  4'd7, 1023,   0, 1'b0};
        tbl[7] = '{    0,    3,    0, 4'd15,  100,  50, 1'b1};

        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) write_pt(i, tbl[i]);

        // Start request without tracking lock must be ignored.
        basis_valid = 1'b0;
        start_frame();
        repeat (3) tick();
        chk("nolock_busy", 64'({busy, pt_valid, done}), 64'(0));

        // Frame 1: ready held high, full sweep.
        basis_valid = 1'b1;
        pt_ready    = 1'b1;
        push_frame(1'b0);
        start_frame();
        chk("f1_busy", 64'(busy), 64'(1));
        n = 0;
        while (!pt_valid && n < 20) begin
            tick();
            n++;
        end
        chk("f1_first_latency", 64'(n), 64'(PL + 1));
        wait_done("f1_done_timeout");
        done_edge = cyc;
        chk("f1_hs_count", 64'(hs_count), 64'(8));
        if (hs_edge.size() == 8) begin
            for (int k = 1; k < 8; k++)
                chk($sformatf("f1_spacing%0d", k), 64'(hs_edge[k] - hs_edge[k-1]), 64'(PL + 2));
            chk("f1_done_timing", 64'(done_edge), 64'(hs_edge[7]));
        end else begin
            chk("f1_hs_edges", 64'(hs_edge.size()), 64'(8));
        end
        tick();
        chk("f1_done_pulses", 64'(done_count), 64'(1));
        chk("f1_idle", 64'({busy, done}), 64'(0));
        chk("f1_sb_empty", 64'(sbq.size()), 64'(0));

        // Frame 2: overrun, write while busy, lock loss, stall on point 3.
        push_frame(1'b0);
        start_frame();
        wait_hs("f2_reach_p3", 11);
        pt_ready    = 1'b0;
        frame_start = 1'b1;
        wr_en       = 1'b1;
        wr_addr     = 3'd0;
        wr_scalars  = {16'sd0, 16'sd0, 16'sd500};
        wr_color    = 4'd9;
        tick();
        frame_start = 1'b0;
        wr_en       = 1'b0;
        chk("f2_overrun_pulse", 64'({overrun, busy}), 64'(3));
        basis_valid = 1'b0;
        tick();
        chk("f2_overrun_clear", 64'(overrun), 64'(0));
        wait_valid("f2_p3_valid");
        snap = {pt_x, pt_y, pt_color, pt_visible, pt_last};
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("f2_stall%0d", k), 64'({pt_valid, pt_x, pt_y, pt_color, pt_visible, pt_last}),
                64'({1'b1, snap}));
        end
        pt_ready = 1'b1;
        wait_done("f2_done_timeout");
        tick();
        chk("f2_hs_count", 64'(hs_count), 64'(16));
        chk("f2_done_pulses", 64'(done_count), 64'(2));
        chk("f2_sb_empty", 64'(sbq.size()), 64'(0));

        // Frame 3: reset while point 5 is presented.
        basis_valid = 1'b1;
        push_frame(1'b0);
        start_frame();
        wait_hs("f3_reach_p5", 21);
        pt_ready = 1'b0;
        wait_valid("f3_p5_valid");
        rst_n = 1'b0;
        sbq.delete();
        tick();
        rst_n = 1'b1;
        check_reset_outputs("midreset");
        dc = done_count;
        repeat (4) tick();
        chk("f3_no_done", 64'(done_count), 64'(dc));
        chk("f3_idle", 64'(busy), 64'(0));

        // Frame 4: memory was cleared by reset.
        pt_ready = 1'b1;
        push_frame(1'b1);
        start_frame();
        wait_done("f4_done_timeout");
        tick();
        chk("f4_hs_count", 64'(hs_count), 64'(29));
        chk("f4_done_pulses", 64'(done_count), 64'(3));
        chk("f4_sb_empty", 64'(sbq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
